// File: rtl/unidade_controle_ula_mc.sv
// Multicycle MIPS32 control FSM: decodes opcode/funct into ALU code and operand selects,
// sequences datapath strobes and handshakes with a variable-latency memory.
module unidade_controle_ula_mc #(
   parameter int unsigned TIMEOUT_CICLOS = 255,
   parameter int unsigned LARG_CONT      = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero_flag,
   input  logic       mem_pronta,
   output logic [3:0] codigo_controle,
   output logic       ir_escreve,
   output logic       pc_escreve,
   output logic       mem_le,
   output logic       mem_escreve,
   output logic       iord,
   output logic       reg_escreve,
   output logic [1:0] sel_wb,
   output logic [1:0] sel_ula_a,
   output logic [2:0] sel_ula_b,
   output logic [1:0] sel_pc,
   output logic [3:0] estado,
   output logic [1:0] erro
);

   typedef enum logic [3:0] {
      ST_BUSCA  = 4'd0,  ST_DECOD  = 4'd1,  ST_END    = 4'd2,  ST_LEMEM  = 4'd3,
      ST_ESCMEM = 4'd4,  ST_WBMEM  = 4'd5,  ST_EXR    = 4'd6,  ST_WBR    = 4'd7,
      ST_DESVIO = 4'd8,  ST_SALTO  = 4'd9,  ST_EXI    = 4'd10, ST_WBI    = 4'd11,
      ST_JAL    = 4'd12, ST_JR     = 4'd13, ST_TRAP   = 4'd14
   } estado_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_JAL  = 6'b000011;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_SLTI = 6'b001010;
   localparam logic [5:0] OP_SLTIU= 6'b001011;
   localparam logic [5:0] OP_ANDI = 6'b001100;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_XORI = 6'b001110;
   localparam logic [5:0] OP_LUI  = 6'b001111;
   localparam logic [5:0] FN_JR   = 6'b001000;

   // Timeout fires on the wait cycle whose count would reach TIMEOUT_CICLOS.
   localparam logic [LARG_CONT-1:0] LIMITE = LARG_CONT'(TIMEOUT_CICLOS - 1);

   estado_t              r_estado, w_prox;
   logic [LARG_CONT-1:0] r_contador;
   logic [1:0]           r_erro, w_erro_prox;
   logic                 w_estouro, w_espera;

   logic       w_r_valido, w_r_shift;
   logic [3:0] w_r_cod, w_i_cod;
   logic       w_i_zext, w_i_lui;

   logic [3:0] w_cod;
   logic       w_ir, w_pcw, w_mle, w_mes, w_iord, w_rw;
   logic [1:0] w_wb, w_a, w_pc;
   logic [2:0] w_b;

   always_comb begin
      w_r_valido = 1'b1;
      w_r_shift  = 1'b0;
      w_r_cod    = 4'b0000;
      case (funct)
         6'b100000: w_r_cod = 4'b0000;
         6'b100010: w_r_cod = 4'b0001;
         6'b100100: w_r_cod = 4'b0010;
         6'b100101: w_r_cod = 4'b0011;
         6'b100110: w_r_cod = 4'b0101;
         6'b100111: w_r_cod = 4'b0110;
         6'b101010: w_r_cod = 4'b0100;
         6'b101011: w_r_cod = 4'b1010;
         6'b000000: begin w_r_cod = 4'b0111; w_r_shift = 1'b1; end
         6'b000010: begin w_r_cod = 4'b1000; w_r_shift = 1'b1; end
         6'b000011: begin w_r_cod = 4'b1001; w_r_shift = 1'b1; end
         default:   w_r_valido = 1'b0;
      endcase
   end

   always_comb begin
      w_i_cod  = 4'b0000;
      w_i_zext = 1'b0;
      w_i_lui  = 1'b0;
      case (opcode)
         OP_SLTI:  w_i_cod = 4'b0100;
         OP_SLTIU: w_i_cod = 4'b1010;
         OP_ANDI:  begin w_i_cod = 4'b0010; w_i_zext = 1'b1; end
         OP_ORI:   begin w_i_cod = 4'b0011; w_i_zext = 1'b1; end
         OP_XORI:  begin w_i_cod = 4'b0101; w_i_zext = 1'b1; end
         OP_LUI:   begin w_i_cod = 4'b0111; w_i_lui  = 1'b1; end
         default:  w_i_cod = 4'b0000;
      endcase
   end

   assign w_estouro = (r_contador == LIMITE);
   assign w_espera  = (r_estado == ST_BUSCA) || (r_estado == ST_LEMEM) || (r_estado == ST_ESCMEM);

   always_comb begin
      w_prox      = r_estado;
      w_erro_prox = r_erro;
      w_cod = 4'b0000;
      w_ir  = 1'b0; w_pcw = 1'b0; w_mle = 1'b0; w_mes = 1'b0; w_iord = 1'b0; w_rw = 1'b0;
      w_wb  = 2'b00; w_a = 2'b00; w_b = 3'b000; w_pc = 2'b00;
      case (r_estado)
         ST_BUSCA: begin
            w_mle = 1'b1;
            w_b   = 3'b001;
            if (mem_pronta) begin
               w_ir   = 1'b1;
               w_pcw  = 1'b1;
               w_prox = ST_DECOD;
            end else if (w_estouro) begin
               w_prox      = ST_TRAP;
               w_erro_prox = 2'b10;
            end
         end
         ST_DECOD: begin
            w_b = 3'b110;
            case (opcode)
               OP_R:           w_prox = (funct == FN_JR) ? ST_JR : ST_EXR;
               OP_LW, OP_SW:   w_prox = ST_END;
               OP_BEQ, OP_BNE: w_prox = ST_DESVIO;
               OP_J:           w_prox = ST_SALTO;
               OP_JAL:         w_prox = ST_JAL;
               OP_ADDI, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI:
                               w_prox = ST_EXI;
               default: begin
                  w_prox      = ST_TRAP;
                  w_erro_prox = 2'b01;
               end
            endcase
         end
         ST_END: begin
            w_a    = 2'b01;
            w_b    = 3'b010;
            w_prox = (opcode == OP_SW) ? ST_ESCMEM : ST_LEMEM;
         end
         ST_LEMEM: begin
            w_mle  = 1'b1;
            w_iord = 1'b1;
            if (mem_pronta) begin
               w_prox = ST_WBMEM;
            end else if (w_estouro) begin
               w_prox      = ST_TRAP;
               w_erro_prox = 2'b10;
            end
         end
         ST_ESCMEM: begin
            w_mes  = 1'b1;
            w_iord = 1'b1;
            if (mem_pronta) begin
               w_prox = ST_BUSCA;
            end else if (w_estouro) begin
               w_prox      = ST_TRAP;
               w_erro_prox = 2'b10;
            end
         end
         ST_WBMEM: begin
            w_rw   = 1'b1;
            w_wb   = 2'b10;
            w_prox = ST_BUSCA;
         end
         ST_EXR: begin
            if (w_r_valido) begin
               w_cod  = w_r_cod;
               w_a    = w_r_shift ? 2'b10 : 2'b01;
               w_b    = w_r_shift ? 3'b100 : 3'b000;
               w_prox = ST_WBR;
            end else begin
               w_prox      = ST_TRAP;
               w_erro_prox = 2'b01;
            end
         end
         ST_WBR: begin
            w_rw   = 1'b1;
            w_prox = ST_BUSCA;
         end
         ST_DESVIO: begin
            w_a    = 2'b01;
            w_cod  = 4'b0001;
            w_pc   = 2'b01;
            w_pcw  = (opcode == OP_BEQ) ? zero_flag : ~zero_flag;
            w_prox = ST_BUSCA;
         end
         ST_SALTO: begin
            w_pcw  = 1'b1;
            w_pc   = 2'b10;
            w_prox = ST_BUSCA;
         end
         ST_EXI: begin
            w_cod  = w_i_cod;
            w_a    = w_i_lui ? 2'b11 : 2'b01;
            w_b    = w_i_lui ? 3'b101 : (w_i_zext ? 3'b011 : 3'b010);
            w_prox = ST_WBI;
         end
         ST_WBI: begin
            w_rw   = 1'b1;
            w_wb   = 2'b01;
            w_prox = ST_BUSCA;
         end
         ST_JAL: begin
            w_rw   = 1'b1;
            w_wb   = 2'b11;
            w_pcw  = 1'b1;
            w_pc   = 2'b10;
            w_prox = ST_BUSCA;
         end
         ST_JR: begin
            w_a    = 2'b01;
            w_cod  = 4'b1011;
            w_pcw  = 1'b1;
            w_prox = ST_BUSCA;
         end
         ST_TRAP:  w_prox = ST_TRAP;
         default:  w_prox = ST_BUSCA;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_estado   <= ST_BUSCA;
         r_contador <= '0;
         r_erro     <= 2'b00;
      end else begin
         r_estado <= w_prox;
         r_erro   <= w_erro_prox;
         if (w_prox != r_estado) begin
            r_contador <= '0;
         end else if (w_espera && !mem_pronta) begin
            r_contador <= r_contador + LARG_CONT'(1);
         end
      end
   end

   // Strobes are suppressed while reset is held so no write lands on a reset cycle.
   assign ir_escreve      = w_ir  & ~reset;
   assign pc_escreve      = w_pcw & ~reset;
   assign mem_le          = w_mle & ~reset;
   assign mem_escreve     = w_mes & ~reset;
   assign reg_escreve     = w_rw  & ~reset;
   assign iord            = w_iord;
   assign codigo_controle = w_cod;
   assign sel_wb          = w_wb;
   assign sel_ula_a       = w_a;
   assign sel_ula_b       = w_b;
   assign sel_pc          = w_pc;
   assign estado          = r_estado;
   assign erro            = r_erro;

endmodule

// File: tb/tb_unidade_controle_ula_mc.sv
// Self-checking bench: instruction-level model expands each instruction into its expected
// per-cycle control trace; table vectors, directed corner cases and random instruction streams.
module tb_unidade_controle_ula_mc;

   localparam int unsigned TMO = 4;

   typedef struct packed {
      logic [3:0] est;
      logic [3:0] cod;
      logic       ir, pcw, mle, mes, iord, rw;
      logic [1:0] wb, a;
      logic [2:0] b;
      logic [1:0] pc, erro;
   } obs_t;

   typedef struct {
      obs_t       e;
      obs_t       m;
      logic       pr, zf;
      logic [5:0] op, fn;
   } step_t;

   typedef struct {
      logic [5:0] op, fn;
      logic       zf;
      logic [3:0] est, cod;
      logic [1:0] a;
      logic [2:0] b;
      logic [1:0] pc;
      logic       pcw;
   } vec_t;

   localparam logic [5:0] R_FN [11] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03};
   localparam logic [3:0] R_CD [11] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h4, 4'ha, 4'h7, 4'h8, 4'h9};
   localparam logic [5:0] I_OP [7]  = '{6'h08, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f};
   localparam logic [3:0] I_CD [7]  = '{4'h0, 4'h4, 4'ha, 4'h2, 4'h3, 4'h5, 4'h7};
   localparam logic [2:0] I_B  [7]  = '{3'd2, 3'd2, 3'd2, 3'd3, 3'd3, 3'd3, 3'd5};
   localparam logic [1:0] I_A  [7]  = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd3};

   logic       clk = 1'b0;
   logic       reset, zero_flag, mem_pronta;
   logic [5:0] opcode, funct;
   logic [3:0] codigo_controle, estado;
   logic       ir_escreve, pc_escreve, mem_le, mem_escreve, iord, reg_escreve;
   logic [1:0] sel_wb, sel_ula_a, sel_pc, erro;
   logic [2:0] sel_ula_b;
   obs_t       w_obs;

   int unsigned n_chk = 0;
   int unsigned n_pass = 0;
   step_t       q[$];
   obs_t        M_ALL, M_EST, M_RST, M_EXE;
   vec_t        tab[$];

   always #5 clk = ~clk;

   unidade_controle_ula_mc #(.TIMEOUT_CICLOS(TMO), .LARG_CONT(8)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero_flag(zero_flag),
      .mem_pronta(mem_pronta), .codigo_controle(codigo_controle), .ir_escreve(ir_escreve),
      .pc_escreve(pc_escreve), .mem_le(mem_le), .mem_escreve(mem_escreve), .iord(iord),
      .reg_escreve(reg_escreve), .sel_wb(sel_wb), .sel_ula_a(sel_ula_a), .sel_ula_b(sel_ula_b),
      .sel_pc(sel_pc), .estado(estado), .erro(erro)
   );

   always_comb begin
      w_obs      = '0;
      w_obs.est  = estado;
      w_obs.cod  = codigo_controle;
      w_obs.ir   = ir_escreve;
      w_obs.pcw  = pc_escreve;
      w_obs.mle  = mem_le;
      w_obs.mes  = mem_escreve;
      w_obs.iord = iord;
      w_obs.rw   = reg_escreve;
      w_obs.wb   = sel_wb;
      w_obs.a    = sel_ula_a;
      w_obs.b    = sel_ula_b;
      w_obs.pc   = sel_pc;
      w_obs.erro = erro;
   end

   function automatic obs_t base(input int unsigned est);
      obs_t o;
      o = '0;
      o.est = 4'(est);
      return o;
   endfunction

   function automatic logic rb();
      return ($urandom_range(0, 1) == 1);
   endfunction

   task automatic chk(input string nm, input obs_t e, input obs_t m);
      logic [$bits(obs_t)-1:0] d;
      n_chk++;
      d = (w_obs ^ e) & m;
      if (d == '0) n_pass++;
      else $display("FAIL %s: got %h expected %h (mask %h) at %0t", nm, w_obs & m, e & m, m, $time);
   endtask

   task automatic step(input string nm, input obs_t e, input obs_t m);
      #4;
      chk(nm, e, m);
      @(posedge clk);
      #1;
   endtask

   task automatic push(input obs_t e, input obs_t m, input logic pr, input logic [5:0] op,
                       input logic [5:0] fn, input logic zf);
      step_t s;
      s.e = e; s.m = m; s.pr = pr; s.zf = zf; s.op = op; s.fn = fn;
      q.push_back(s);
   endtask

   task automatic push_trap(input logic [1:0] err, input logic [5:0] op, input logic [5:0] fn);
      obs_t e;
      e = base(14);
      e.erro = err;
      for (int i = 0; i < 3; i++) push(e, M_ALL, rb(), op, fn, rb());
   endtask

   // A memory phase lasts w stalled cycles plus the completion cycle, unless the stall
   // count reaches TMO first, in which case the controller traps with a timeout.
   task automatic wait_ph(input obs_t ew, input obs_t ed, input int unsigned w, input logic [5:0] op,
                          input logic [5:0] fn, input logic zf, output bit tr);
      for (int unsigned i = 0; i < w && i < TMO; i++) push(ew, M_ALL, 1'b0, op, fn, zf);
      tr = (w >= TMO);
      if (tr) push_trap(2'b10, op, fn);
      else push(ed, M_ALL, 1'b1, op, fn, zf);
   endtask

   task automatic gen(input logic [5:0] op, input logic [5:0] fn, input int unsigned wf,
                      input int unsigned wm, input logic zf);
      obs_t e, d;
      bit   tr, ok;
      int   k;
      e = base(0); e.mle = 1'b1; e.b = 3'b001;
      d = e; d.ir = 1'b1; d.pcw = 1'b1;
      wait_ph(e, d, wf, op, fn, zf, tr);
      if (tr) return;
      e = base(1); e.b = 3'b110;
      push(e, M_ALL, rb(), op, fn, zf);
      if (op == 6'h00 && fn == 6'h08) begin
         e = base(13); e.a = 2'b01; e.cod = 4'hb; e.pcw = 1'b1;
         push(e, M_ALL, rb(), op, fn, zf);
      end else if (op == 6'h00) begin
         k = -1;
         for (int i = 0; i < 11; i++) if (R_FN[i] == fn) k = i;
         e = base(6);
         if (k < 0) begin
            push(e, M_EST, rb(), op, fn, zf);
            push_trap(2'b01, op, fn);
         end else begin
            e.cod = R_CD[k];
            e.a = (k >= 8) ? 2'b10 : 2'b01;
            e.b = (k >= 8) ? 3'b100 : 3'b000;
            push(e, M_ALL, rb(), op, fn, zf);
            e = base(7); e.rw = 1'b1;
            push(e, M_ALL, rb(), op, fn, zf);
         end
      end else if (op == 6'h23 || op == 6'h2b) begin
         e = base(2); e.a = 2'b01; e.b = 3'b010;
         push(e, M_ALL, rb(), op, fn, zf);
         if (op == 6'h23) begin
            e = base(3); e.mle = 1'b1; e.iord = 1'b1;
            wait_ph(e, e, wm, op, fn, zf, tr);
            if (!tr) begin
               e = base(5); e.rw = 1'b1; e.wb = 2'b10;
               push(e, M_ALL, rb(), op, fn, zf);
            end
         end else begin
            e = base(4); e.mes = 1'b1; e.iord = 1'b1;
            wait_ph(e, e, wm, op, fn, zf, tr);
         end
      end else if (op == 6'h04 || op == 6'h05) begin
         e = base(8); e.a = 2'b01; e.cod = 4'h1; e.pc = 2'b01;
         e.pcw = (op == 6'h04) ? zf : !zf;
         push(e, M_ALL, rb(), op, fn, zf);
      end else if (op == 6'h02) begin
         e = base(9); e.pcw = 1'b1; e.pc = 2'b10;
         push(e, M_ALL, rb(), op, fn, zf);
      end else if (op == 6'h03) begin
         e = base(12); e.rw = 1'b1; e.wb = 2'b11; e.pcw = 1'b1; e.pc = 2'b10;
         push(e, M_ALL, rb(), op, fn, zf);
      end else begin
         ok = 1'b0;
         for (int i = 0; i < 7; i++) begin
            if (I_OP[i] == op) begin
               ok = 1'b1;
               e = base(10); e.cod = I_CD[i]; e.a = I_A[i]; e.b = I_B[i];
            end
         end
         if (ok) begin
            push(e, M_ALL, rb(), op, fn, zf);
            e = base(11); e.rw = 1'b1; e.wb = 2'b01;
            push(e, M_ALL, rb(), op, fn, zf);
         end else begin
            push_trap(2'b01, op, fn);
         end
      end
   endtask

   task automatic run_n(input string nm, input int unsigned n);
      step_t s;
      for (int unsigned i = 0; i < n && q.size() > 0; i++) begin
         s = q.pop_front();
         opcode = s.op; funct = s.fn; mem_pronta = s.pr; zero_flag = s.zf;
         step(nm, s.e, s.m);
      end
   endtask

   task automatic run_q(input string nm);
      run_n(nm, q.size());
   endtask

   task automatic do_reset();
      q.delete();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic add_vec(input logic [5:0] op, input logic [5:0] fn, input logic zf, input int unsigned est,
                          input logic [3:0] cod, input logic [1:0] a, input logic [2:0] b,
                          input logic [1:0] pc, input logic pcw);
      vec_t v;
      v.op = op; v.fn = fn; v.zf = zf; v.est = 4'(est); v.cod = cod;
      v.a = a; v.b = b; v.pc = pc; v.pcw = pcw;
      tab.push_back(v);
   endtask

   initial begin
      obs_t e;
      step_t s;
      logic [5:0] op, fn;
      M_ALL = '1;
      M_EST = '0; M_EST.est = '1;
      M_RST = '0; M_RST.est = '1; M_RST.ir = 1'b1; M_RST.pcw = 1'b1; M_RST.mle = 1'b1;
      M_RST.mes = 1'b1; M_RST.rw = 1'b1; M_RST.erro = '1;
      M_EXE = '0; M_EXE.est = '1; M_EXE.cod = '1; M_EXE.a = '1; M_EXE.b = '1; M_EXE.pc = '1; M_EXE.pcw = 1'b1;

      add_vec(6'h00, 6'h20, 0,  6, 4'h0, 2'd1, 3'd0, 2'd0, 0);
      add_vec(6'h00, 6'h22, 0,  6, 4'h1, 2'd1, 3'd0, 2'd0, 0);
      add_vec(6'h00, 6'h2a, 0,  6, 4'h4, 2'd1, 3'd0, 2'd0, 0);
      add_vec(6'h00, 6'h2b, 0,  6, 4'ha, 2'd1, 3'd0, 2'd0, 0);
      add_vec(6'h00, 6'h27, 0,  6, 4'h6, 2'd1, 3'd0, 2'd0, 0);
      add_vec(6'h00, 6'h00, 0,  6, 4'h7, 2'd2, 3'd4, 2'd0, 0);
      add_vec(6'h00, 6'h03, 0,  6, 4'h9, 2'd2, 3'd4, 2'd0, 0);
      add_vec(6'h00, 6'h08, 0, 13, 4'hb, 2'd1, 3'd0, 2'd0, 1);
      add_vec(6'h08, 6'h11, 0, 10, 4'h0, 2'd1, 3'd2, 2'd0, 0);
      add_vec(6'h0d, 6'h00, 0, 10, 4'h3, 2'd1, 3'd3, 2'd0, 0);
      add_vec(6'h0f, 6'h00, 0, 10, 4'h7, 2'd3, 3'd5, 2'd0, 0);
      add_vec(6'h0b, 6'h00, 0, 10, 4'ha, 2'd1, 3'd2, 2'd0, 0);
      add_vec(6'h04, 6'h00, 1,  8, 4'h1, 2'd1, 3'd0, 2'd1, 1);
      add_vec(6'h04, 6'h00, 0,  8, 4'h1, 2'd1, 3'd0, 2'd1, 0);
      add_vec(6'h05, 6'h00, 1,  8, 4'h1, 2'd1, 3'd0, 2'd1, 0);
      add_vec(6'h05, 6'h00, 0,  8, 4'h1, 2'd1, 3'd0, 2'd1, 1);
      add_vec(6'h02, 6'h00, 0,  9, 4'h0, 2'd0, 3'd0, 2'd2, 1);
      add_vec(6'h03, 6'h00, 0, 12, 4'h0, 2'd0, 3'd0, 2'd2, 1);
      add_vec(6'h23, 6'h00, 0,  2, 4'h0, 2'd1, 3'd2, 2'd0, 0);
      add_vec(6'h2b, 6'h00, 0,  2, 4'h0, 2'd1, 3'd2, 2'd0, 0);

      reset = 1'b1; mem_pronta = 1'b1; zero_flag = 1'b0; opcode = '0; funct = '0;
      @(posedge clk);
      #1;
      e = base(0);
      step("reset_a", e, M_RST);
      step("reset_b", e, M_RST);
      reset = 1'b0;
      gen(6'h00, 6'h20, 0, 0, 0);
      run_q("add_seq");

      foreach (tab[i]) begin
         do_reset();
         opcode = tab[i].op; funct = tab[i].fn; zero_flag = tab[i].zf; mem_pronta = 1'b1;
         @(posedge clk); #1;
         @(posedge clk); #1;
         e = base(tab[i].est);
         e.cod = tab[i].cod; e.a = tab[i].a; e.b = tab[i].b; e.pc = tab[i].pc; e.pcw = tab[i].pcw;
         step($sformatf("vec%0d", i), e, M_EXE);
      end

      do_reset(); gen(6'h23, 6'h00, 0, 3, 0); gen(6'h2b, 6'h00, 1, 2, 0); run_q("lw_sw_wait");
      do_reset(); gen(6'h3f, 6'h00, 0, 0, 0); run_q("op_invalid");
      do_reset(); gen(6'h0c, 6'h00, 0, 0, 0); run_q("trap_exit");
      do_reset(); gen(6'h00, 6'h3f, 0, 0, 0); run_q("funct_invalid");
      do_reset(); gen(6'h00, 6'h20, TMO, 0, 0); run_q("fetch_timeout");
      do_reset(); gen(6'h00, 6'h20, TMO - 1, 0, 0); run_q("fetch_last_cycle");
      do_reset(); gen(6'h23, 6'h00, 0, TMO, 0); run_q("load_timeout");
      do_reset(); gen(6'h2b, 6'h00, 0, TMO - 1, 0); run_q("store_last_cycle");

      do_reset();
      gen(6'h00, 6'h20, 0, 0, 0);
      run_n("mid_reset", 3);
      s = q.pop_front();
      opcode = s.op; funct = s.fn; mem_pronta = s.pr; zero_flag = s.zf;
      reset = 1'b1;
      e = base(7);
      step("mid_reset_wbr", e, M_RST);
      reset = 1'b0;
      q.delete();
      gen(6'h02, 6'h00, 1, 0, 0);
      run_q("after_mid_reset");

      do_reset();
      for (int n = 0; n < 60; n++) begin
         case ($urandom_range(0, 5))
            0: begin op = 6'h00; fn = R_FN[$urandom_range(0, 10)]; end
            1: begin op = 6'h00; fn = 6'h08; end
            2: begin op = I_OP[$urandom_range(0, 6)]; fn = 6'($urandom); end
            3: begin op = rb() ? 6'h23 : 6'h2b; fn = 6'($urandom); end
            4: begin op = rb() ? 6'h04 : 6'h05; fn = 6'($urandom); end
            default: begin op = rb() ? 6'h02 : 6'h03; fn = 6'($urandom); end
         endcase
         gen(op, fn, $urandom_range(0, TMO - 1), $urandom_range(0, TMO - 1), rb());
      end
      run_q("random");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
